i2c_slave_responder: RTL and testbench
======================================

// Module: i2c_slave_responder
// PURPOSE
// Synthesizable I2C slave (responder) for the far end of the iicmb_m_wb bus.
// Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs,
// stores written bytes in a DEPTH-byte buffer and returns buffered bytes on reads.
// A host load port preloads read data; strobes report received bytes and transfer end.
// PARAMETERS
// SLAVE_ADDR   7'h22  7-bit I2C address this responder answers to
// MEM_DEPTH    64     buffer depth in bytes, power of 2; PTR_W = $clog2(MEM_DEPTH)
// PORTS
// clk_i        in   1      system clock (>= 20x SCL rate)
// rst_i        in   1      synchronous reset, active high
// scl_i        in   1      I2C clock from bus (asynchronous)
// sda_i        in   1      I2C data from bus (asynchronous)
// sda_o        out  1      open-drain drive: 0 = pull low, 1 = release
// ld_en_i      in   1      host write strobe into buffer
// ld_addr_i    in   PTR_W  host write index
// ld_data_i    in   8      host write data
// rx_valid_o   out  1      1-cycle pulse: written byte accepted (after ACK driven)
// rx_data_o    out  8      byte accompanying rx_valid_o
// xfer_done_o  out  1      1-cycle pulse at STOP ending an addressed transfer
// rw_o         out  1      R/W bit of last matched address (1 = read)
// busy_o       out  1      1 from matched address until STOP/mismatch/NACK-idle
// BEHAVIOUR
// - Reset: sda_o=1, rx_valid_o=0, rx_data_o=0, xfer_done_o=0, rw_o=0, busy_o=0, state IDLE,
//   wr_ptr=rd_ptr=0, bit_cnt=0; buffer contents not cleared. Reset mid-transfer releases SDA next edge.
// - Sync: 2-flop synchronizer per line plus 1 history flop; rise/fall detected on synced values
//   (3-cycle detection latency). All decisions use synced values only.
// - START: synced SDA falls while synced SCL high -> ADDR, bit_cnt=0, sda_o=1, from ANY state
//   (repeated START included). STOP: SDA rises while SCL high -> IDLE, sda_o=1; xfer_done_o
//   pulses the next cycle iff busy_o was 1; busy_o clears.
// - Bits sampled on SCL rising edge, MSB first; sda_o updates only in the cycle after a detected
//   SCL falling edge (never while SCL high).
// - States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
//   ADDR: after 8th rising edge compare [7:1] to SLAVE_ADDR. Match -> ADDR_ACK, rw_o=bit0,
//     busy_o=1; write: wr_ptr=0; read: rd_ptr=0. Mismatch -> IDLE, SDA never driven.
//   ADDR_ACK: on next SCL fall drive sda_o=0; on following fall release and go WR_DATA, or
//     RD_DATA loading shreg=mem[rd_ptr] and driving bit7 in the same cycle.
//   WR_DATA: 8 bits -> WR_ACK. WR_ACK: drive 0 on fall; mem[wr_ptr]<=byte, wr_ptr++ (wraps
//     mod MEM_DEPTH, overwrites), rx_valid_o pulse with rx_data_o=byte; next fall release -> WR_DATA.
//   RD_DATA: shift out 8 bits; after 8th fall release SDA -> RD_ACK, rd_ptr++ (wraps).
//   RD_ACK: sample master bit on rise: 0 (ACK) -> RD_DATA with next mem[rd_ptr] on next fall;
//     1 (NACK) -> IDLE, sda_o=1, busy_o stays 1 until STOP.
// - ld_en_i writes mem[ld_addr_i] any cycle; same-cycle conflict with WR_ACK store: I2C wins.
// - No clock stretching; SCL never driven.
// TESTING
// - Reset 5 cycles, bus idle -> sda_o=1, busy_o=0, no pulses.
// - START, 0x44, bytes 0x00..0x1F, STOP -> 33 ACKs, 32 rx_valid_o pulses data 0..31 in order,
//   one xfer_done_o, mem[0..31]=0..31.
// - Preload mem[i]=100+i via ld port; START, 0x45, 31 reads ACK + 1 NACK, STOP ->
//   master receives 100..131, SDA released after NACK, xfer_done_o once.
// - START, 0x88 (addr 0x44 mismatch), byte 0x12, STOP -> sda_o stays 1, busy_o=0, no pulses.
// - Write 0x07 to 0x44 then repeated START, read 0x45 one byte NACK, STOP -> rx_data_o=0x07,
//   read returns mem[0]=0x07, rw_o=1, single xfer_done_o.
// - Assert rst_i while driving ACK low mid-write -> sda_o=1 next cycle, state IDLE, busy_o=0.

Source files
------------

// File: rtl/i2c_slave_responder_if.sv
// Bus bundle for the I2C responder: I2C lines, host buffer-load port and status strobes.
interface i2c_slave_responder_if #(
  parameter int unsigned PTR_W = 6
);
  logic             scl_i;
  logic             sda_i;
  logic             sda_o;
  logic             ld_en_i;
  logic [PTR_W-1:0] ld_addr_i;
  logic [7:0]       ld_data_i;
  logic             rx_valid_o;
  logic [7:0]       rx_data_o;
  logic             xfer_done_o;
  logic             rw_o;
  logic             busy_o;

  modport slave (
    input  scl_i, sda_i, ld_en_i, ld_addr_i, ld_data_i,
    output sda_o, rx_valid_o, rx_data_o, xfer_done_o, rw_o, busy_o
  );

  modport master (
    output scl_i, sda_i, ld_en_i, ld_addr_i, ld_data_i,
    input  sda_o, rx_valid_o, rx_data_o, xfer_done_o, rw_o, busy_o
  );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C responder: oversampled SCL/SDA, START/STOP detect, 7-bit address match,
// write bytes into a circular buffer and serve reads from it.
module i2c_slave_responder #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h22,
  parameter int unsigned MEM_DEPTH  = 64
) (
  input logic                  clk_i,
  input logic                  rst_i,
  i2c_slave_responder_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrData, StWrAck, StRdData, StRdAck
  } state_e;

  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  state_e           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             ack_q, ack_d;  // second-phase flag inside ACK states
  logic             sda_q, sda_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             xfer_done_q, xfer_done_d;
  logic             rw_q, rw_d;
  logic             busy_q, busy_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             mem_we;
  logic [7:0]       mem_q [MEM_DEPTH];
  logic [7:0]       rd_byte;

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_sync_q & ~scl_hist_q;
  assign scl_fall  = ~scl_sync_q & scl_hist_q;
  assign start_det = scl_sync_q & ~sda_sync_q & sda_hist_q;
  assign stop_det  = scl_sync_q & sda_sync_q & ~sda_hist_q;
  assign rd_byte   = mem_q[rd_ptr_q];

  // Two-flop synchronizers plus a history flop for edge detection; idle bus is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {scl_meta_q, scl_sync_q, scl_hist_q} <= 3'b111;
      {sda_meta_q, sda_sync_q, sda_hist_q} <= 3'b111;
    end else begin
      {scl_meta_q, scl_sync_q, scl_hist_q} <= {bus.scl_i, scl_meta_q, scl_sync_q};
      {sda_meta_q, sda_sync_q, sda_hist_q} <= {bus.sda_i, sda_meta_q, sda_sync_q};
    end
  end

  // Protocol FSM next-state and output decode.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    ack_d       = ack_q;
    sda_d       = sda_q;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    xfer_done_d = 1'b0;
    rw_d        = rw_q;
    busy_d      = busy_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_we      = 1'b0;
    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = 3'd0;
      ack_d     = 1'b0;
      sda_d     = 1'b1;
    end else if (stop_det) begin
      state_d     = StIdle;
      sda_d       = 1'b1;
      xfer_done_d = busy_q;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[6:0], sda_sync_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shreg_q[6:0] == SLAVE_ADDR) begin
                state_d = StAddrAck;
                ack_d   = 1'b0;
                rw_d    = sda_sync_q;
                busy_d  = 1'b1;
                if (sda_sync_q) rd_ptr_d = '0;
                else            wr_ptr_d = '0;
              end else begin
                state_d = StIdle;
                busy_d  = 1'b0;
              end
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (!ack_q) begin
              sda_d = 1'b0;
              ack_d = 1'b1;
            end else begin
              ack_d     = 1'b0;
              bit_cnt_d = 3'd0;
              if (rw_q) begin
                state_d = StRdData;
                shreg_d = rd_byte;
                sda_d   = rd_byte[7];
              end else begin
                state_d = StWrData;
                sda_d   = 1'b1;
              end
            end
          end
        end
        StWrData: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[6:0], sda_sync_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = StWrAck;
              ack_d   = 1'b0;
            end
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            if (!ack_q) begin
              sda_d      = 1'b0;
              ack_d      = 1'b1;
              mem_we     = 1'b1;
              wr_ptr_d   = wr_ptr_q + 1'b1;
              rx_valid_d = 1'b1;
              rx_data_d  = shreg_q;
            end else begin
              ack_d     = 1'b0;
              sda_d     = 1'b1;
              bit_cnt_d = 3'd0;
              state_d   = StWrData;
            end
          end
        end
        StRdData: begin
          // Bit 7 went out on entry; each fall drives the next bit, the 8th releases.
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_d    = 1'b1;
              ack_d    = 1'b0;
              rd_ptr_d = rd_ptr_q + 1'b1;
              state_d  = StRdAck;
            end else begin
              shreg_d   = {shreg_q[6:0], 1'b0};
              sda_d     = shreg_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (sda_sync_q) begin
              state_d = StIdle;
              sda_d   = 1'b1;
            end else begin
              ack_d = 1'b1;
            end
          end else if (scl_fall && ack_q) begin
            ack_d     = 1'b0;
            state_d   = StRdData;
            shreg_d   = rd_byte;
            sda_d     = rd_byte[7];
            bit_cnt_d = 3'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      shreg_q     <= 8'd0;
      bit_cnt_q   <= 3'd0;
      ack_q       <= 1'b0;
      sda_q       <= 1'b1;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'd0;
      xfer_done_q <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      ack_q       <= ack_d;
      sda_q       <= sda_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      xfer_done_q <= xfer_done_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Buffer writes; the I2C store is issued last so it wins a same-address conflict.
  always_ff @(posedge clk_i) begin
    if (bus.ld_en_i) mem_q[bus.ld_addr_i] <= bus.ld_data_i;
    if (mem_we)      mem_q[wr_ptr_q]      <= shreg_q;
  end

  assign bus.sda_o       = sda_q;
  assign bus.rx_valid_o  = rx_valid_q;
  assign bus.rx_data_o   = rx_data_q;
  assign bus.xfer_done_o = xfer_done_q;
  assign bus.rw_o        = rw_q;
  assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: bit-banged I2C master on a wired-AND SDA.
module tb_i2c_slave_responder;
  localparam int unsigned Q = 10;  // quarter SCL period in clk cycles

  logic clk, rst, m_scl, m_sda;
  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int done_cnt = 0;
  int low_cnt = 0;
  logic [7:0] rx_log[$];

  i2c_slave_responder_if #(.PTR_W(6)) bus ();

  i2c_slave_responder #(
    .SLAVE_ADDR(7'h22),
    .MEM_DEPTH (64)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & bus.sda_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and SDA-drive monitors.
  always @(negedge clk) begin
    if (bus.rx_valid_o === 1'b1) begin
      rx_cnt++;
      rx_log.push_back(bus.rx_data_o);
    end
    if (bus.xfer_done_o === 1'b1) done_cnt++;
    if (bus.sda_o === 1'b0) low_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    m_sda = b;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    r = bus.sda_i;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b1;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(nack, r);
  endtask

  initial begin
    int acks, rb, db, lb;
    logic ack, r;
    logic [7:0] d;
    logic [7:0] addr_w;

    rst = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    bus.ld_en_i = 1'b0;
    bus.ld_addr_i = '0;
    bus.ld_data_i = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    wait_q();

    // Reset state on an idle bus
    chk("rst_sda", 32'(bus.sda_o), 32'd1);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_rw", 32'(bus.rw_o), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data_o), 32'd0);
    chk("rst_rx_pulses", rx_cnt, 0);
    chk("rst_done_pulses", done_cnt, 0);

    // Write 0x00..0x1F to address 0x22
    rb = rx_cnt;
    db = done_cnt;
    acks = 0;
    i2c_start();
    write_byte(8'h44, ack);
    acks += int'(ack);
    for (int i = 0; i < 32; i++) begin
      write_byte(8'(i), ack);
      acks += int'(ack);
    end
    i2c_stop();
    wait_q();
    chk("wr_acks", acks, 33);
    chk("wr_rx_pulses", rx_cnt - rb, 32);
    chk("wr_done", done_cnt - db, 1);
    chk("wr_busy_after", 32'(bus.busy_o), 32'd0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("wr_rx_data%0d", i), 32'(rx_log[rb + i]), 32'(i));
      chk($sformatf("wr_mem%0d", i), 32'(dut.mem_q[i]), 32'(i));
    end

    // Preload 100+i, read 32 bytes (last NACK)
    for (int i = 0; i < 32; i++) begin
      bus.ld_en_i = 1'b1;
      bus.ld_addr_i = 6'(i);
      bus.ld_data_i = 8'(100 + i);
      @(negedge clk);
    end
    bus.ld_en_i = 1'b0;
    db = done_cnt;
    i2c_start();
    write_byte(8'h45, ack);
    chk("rd_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 32; i++) begin
      read_byte(i == 31, d);
      chk($sformatf("rd_data%0d", i), 32'(d), 32'(100 + i));
    end
    wait_q();
    chk("rd_sda_released", 32'(bus.sda_o), 32'd1);
    chk("rd_busy_before_stop", 32'(bus.busy_o), 32'd1);
    chk("rd_rw", 32'(bus.rw_o), 32'd1);
    i2c_stop();
    wait_q();
    chk("rd_done", done_cnt - db, 1);
    chk("rd_busy_after", 32'(bus.busy_o), 32'd0);

    // Address mismatch: 0x88 is address 0x44
    rb = rx_cnt;
    db = done_cnt;
    lb = low_cnt;
    i2c_start();
    write_byte(8'h88, ack);
    chk("mm_nack", 32'(ack), 32'd0);
    write_byte(8'h12, ack);
    chk("mm_data_nack", 32'(ack), 32'd0);
    i2c_stop();
    wait_q();
    chk("mm_sda_never_low", low_cnt - lb, 0);
    chk("mm_busy", 32'(bus.busy_o), 32'd0);
    chk("mm_rx_pulses", rx_cnt - rb, 0);
    chk("mm_done", done_cnt - db, 0);

    // Write 0x07, repeated START, read one byte back
    rb = rx_cnt;
    db = done_cnt;
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h07, ack);
    chk("rs_wr_ack", 32'(ack), 32'd1);
    i2c_start();
    write_byte(8'h45, ack);
    chk("rs_rd_addr_ack", 32'(ack), 32'd1);
    read_byte(1'b1, d);
    i2c_stop();
    wait_q();
    chk("rs_rx_pulses", rx_cnt - rb, 1);
    chk("rs_rx_data", 32'(bus.rx_data_o), 32'h07);
    chk("rs_rd_data", 32'(d), 32'h07);
    chk("rs_rw", 32'(bus.rw_o), 32'd1);
    chk("rs_done", done_cnt - db, 1);

    // Reset while driving the address ACK low
    db = done_cnt;
    addr_w = 8'h44;
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(addr_w[i], r);
    m_sda = 1'b1;
    wait_q();
    chk("rr_ack_driven", 32'(bus.sda_o), 32'd0);
    chk("rr_busy_before", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_sda", 32'(bus.sda_o), 32'd1);
    chk("rr_busy", 32'(bus.busy_o), 32'd0);
    chk("rr_state", 32'(dut.state_q), 32'd0);
    rst = 1'b0;
    i2c_stop();
    wait_q();
    chk("rr_done", done_cnt - db, 0);
    chk("rr_busy_end", 32'(bus.busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
